matvec_nxn_pipe: RTL and testbench



---
 rtl/matvec_nxn_pipe_pkg.sv | 37 +++
 rtl/matvec_nxn_pipe_dot_row.sv | 78 +++++++
 rtl/matvec_nxn_pipe.sv | 62 ++++++
 tb/tb_matvec_nxn_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_nxn_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matvec_pkg : width helpers and saturating resize for matvec_nxn_pipe       |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package matvec_pkg;

  // Product width: a full signed DW x DW product (-2^(DW-1) squared needs 2*DW bits)
  function automatic int pw_f(input int dw);
    return 2 * dw;
  endfunction

  // Sum width: product width plus growth for N terms
  function automatic int sw_f(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic logic signed [63:0] sat_hi(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction

  function automatic logic sat_ovf(input logic signed [63:0] v, input int ow);
    return (v > sat_hi(ow)) || (v < sat_lo(ow));
  endfunction

  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v, input int ow);
    if (v > sat_hi(ow)) return sat_hi(ow);
    if (v < sat_lo(ow)) return sat_lo(ow);
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_nxn_pipe_dot_row.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matvec_dot_row : one row of the matrix-vector product, 2 register stages   |
// | Clamps on overflow when MATVEC_SAT_EN is defined, otherwise wraps.         |
// | Revision       : 1.0  initial release                                      |
// +----------------------------------------------------------------------------+
module matvec_dot_row
  import matvec_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 9,
  parameter int OW = sw_f(DW, N)
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              ien,
  input  logic [N*DW-1:0]   irow,
  input  logic [N*DW-1:0]   ivec,
  output logic [OW-1:0]     odata,
  output logic              osat
);

  localparam int PW = pw_f(DW);
  localparam int SW = sw_f(DW, N);

  logic signed [PW-1:0] w_a    [N];
  logic signed [PW-1:0] w_b    [N];
  logic signed [PW-1:0] r_prod [N];
  logic signed [SW-1:0] w_sum;
  logic signed [OW-1:0] w_res;
  logic        [OW-1:0] r_data;

  for (genvar c = 0; c < N; c++) begin : g_col
    assign w_a[c] = PW'($signed(irow[c*DW +: DW]));
    assign w_b[c] = PW'($signed(ivec[c*DW +: DW]));
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int c = 0; c < N; c++) r_prod[c] <= '0;
    end else if (ien) begin
      for (int c = 0; c < N; c++) r_prod[c] <= w_a[c] * w_b[c];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < N; c++) w_sum = w_sum + SW'(r_prod[c]);
  end

`ifdef MATVEC_SAT_EN
  logic w_ovf;
  logic r_sat;

  assign w_res = OW'(sat_resize(64'(w_sum), OW));
  assign w_ovf = sat_ovf(64'(w_sum), OW);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)   r_sat <= 1'b0;
    else if (ien)  r_sat <= w_ovf;
  end

  assign osat = r_sat;
`else
  // Sign-extend first so OW wider than SW also works, then keep the low OW bits
  assign w_res = OW'(64'(w_sum));
  assign osat  = 1'b0;
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)   r_data <= '0;
    else if (ien)  r_data <= w_res;
  end

  assign odata = r_data;

endmodule
`default_nettype wire

// File: rtl/matvec_nxn_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matvec_nxn_pipe : signed NxN matrix times Nx1 vector, 2-stage pipeline     |
// | with valid/ready back-pressure. Optional clamp via MATVEC_SAT_EN.          |
// | Revision        : 1.0  initial release                                     |
// +----------------------------------------------------------------------------+
module matvec_nxn_pipe
  import matvec_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 9,
  parameter int OW = sw_f(DW, N)
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic [N*N*DW-1:0] iData_a,
  input  logic [N*DW-1:0]   iData_b,
  input  logic              ivalid,
  output logic              oready,
  output logic [N*OW-1:0]   odata,
  output logic              ovalid,
  input  logic              iready,
  output logic [N-1:0]      osat
);

  logic w_en;
  logic r_v1;
  logic r_ovalid;

  // The whole pipeline moves unless a valid result is waiting on downstream
  assign w_en   = iready | ~r_ovalid;
  assign oready = w_en;
  assign ovalid = r_ovalid;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_v1     <= 1'b0;
      r_ovalid <= 1'b0;
    end else if (w_en) begin
      r_v1     <= ivalid;
      r_ovalid <= r_v1;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    matvec_dot_row #(
      .N  (N),
      .DW (DW),
      .OW (OW)
    ) u_row (
      .iclk   (iclk),
      .irst_n (irst_n),
      .ien    (w_en),
      .irow   (iData_a[r*N*DW +: N*DW]),
      .ivec   (iData_b),
      .odata  (odata[r*OW +: OW]),
      .osat   (osat[r])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_matvec_nxn_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matvec_nxn_pipe : self-checking bench, lossless and 16-bit output DUTs  |
// | Revision           : 1.0  initial release                                  |
// +----------------------------------------------------------------------------+
module tb_matvec_nxn_pipe;

  localparam int N   = 3;
  localparam int DW  = 9;
  localparam int OW  = 20;
  localparam int OWN = 16;

  logic              iclk   = 1'b0;
  logic              irst_n = 1'b0;
  logic [N*N*DW-1:0] iData_a = '0;
  logic [N*DW-1:0]   iData_b = '0;
  logic              ivalid = 1'b0;
  logic              iready = 1'b1;
  logic              oready, ovalid, oready_n, ovalid_n;
  logic [N*OW-1:0]   odata;
  logic [N*OWN-1:0]  odata_n;
  logic [N-1:0]      osat, osat_n;

  int vectors = 0;
  int errors  = 0;
  int a [N][N];
  int b [N];

  always #5 iclk = ~iclk;

  matvec_nxn_pipe #(.N(N), .DW(DW)) dut (
    .iclk(iclk), .irst_n(irst_n), .iData_a(iData_a), .iData_b(iData_b),
    .ivalid(ivalid), .oready(oready), .odata(odata), .ovalid(ovalid),
    .iready(iready), .osat(osat)
  );

  matvec_nxn_pipe #(.N(N), .DW(DW), .OW(OWN)) dut_n (
    .iclk(iclk), .irst_n(irst_n), .iData_a(iData_a), .iData_b(iData_b),
    .ivalid(ivalid), .oready(oready_n), .odata(odata_n), .ovalid(ovalid_n),
    .iready(iready), .osat(osat_n)
  );

  // ---------------- reference model ----------------
  function automatic longint row_val(input int r);
    longint s = 0;
    for (int c = 0; c < N; c++) s += longint'(a[r][c]) * longint'(b[c]);
    return s;
  endfunction

  function automatic logic [N*OW-1:0] exp_wide();
    logic [N*OW-1:0] v;
    for (int r = 0; r < N; r++) v[r*OW +: OW] = OW'(row_val(r));
    return v;
  endfunction

  function automatic logic [OWN-1:0] narrow(input longint v, output logic s);
    longint hi = (longint'(1) << (OWN - 1)) - 1;
    longint lo = -(longint'(1) << (OWN - 1));
`ifdef MATVEC_SAT_EN
    if (v > hi) begin s = 1'b1; return OWN'(hi); end
    if (v < lo) begin s = 1'b1; return OWN'(lo); end
    s = 1'b0;
    return OWN'(v);
`else
    s = (hi < lo);
    return v[OWN-1:0];
`endif
  endfunction

  task automatic load_beat();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) iData_a[(r*N+c)*DW +: DW] = DW'(a[r][c]);
      iData_b[r*DW +: DW] = DW'(b[r]);
    end
  endtask

  task automatic rand_beat(input int lo, input int hi);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) a[r][c] = int'($urandom_range(hi - lo)) + lo;
      b[r] = int'($urandom_range(hi - lo)) + lo;
    end
    load_beat();
  endtask

  task automatic drain();
    ivalid = 1'b0;
    iready = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    irst_n = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    vectors++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b want 0", ovalid); end
    vectors++; if (odata !== '0) begin errors++; $display("FAIL reset_odata got %h want 0", odata); end
    vectors++; if (osat !== '0 || osat_n !== '0) begin errors++; $display("FAIL reset_osat got %b/%b want 0", osat, osat_n); end
    vectors++; if (oready !== 1'b1) begin errors++; $display("FAIL reset_oready got %b want 1", oready); end
    irst_n = 1'b1;
    @(posedge iclk);
    #1;
  endtask

  task automatic test_identity();
    logic [N*OW-1:0] e;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) a[r][c] = (r == c) ? 1 : 0;
    b[0] = 5; b[1] = -7; b[2] = 100;
    load_beat();
    e = {20'sd100, -20'sd7, 20'sd5};
    ivalid = 1'b1; iready = 1'b1;
    @(posedge iclk); #1;
    ivalid = 1'b0;
    vectors++; if (ovalid !== 1'b0) begin errors++; $display("FAIL ident_lat1 ovalid got %b want 0", ovalid); end
    @(posedge iclk); #1;
    vectors++; if (ovalid !== 1'b1) begin errors++; $display("FAIL ident_lat2 ovalid got %b want 1", ovalid); end
    vectors++; if (odata !== e) begin errors++; $display("FAIL ident_data got %h want %h", odata, e); end
    vectors++; if (osat !== '0) begin errors++; $display("FAIL ident_osat got %b want 0", osat); end
    @(posedge iclk); #1;
    vectors++; if (ovalid !== 1'b0) begin errors++; $display("FAIL ident_after ovalid got %b want 0", ovalid); end
    drain();
  endtask

  task automatic test_all_neg();
    logic [N*OW-1:0] e;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) a[r][c] = -256;
      b[r] = -256;
    end
    load_beat();
    for (int r = 0; r < N; r++) e[r*OW +: OW] = OW'(196608);
    ivalid = 1'b1; iready = 1'b1;
    @(posedge iclk); #1;
    ivalid = 1'b0;
    @(posedge iclk); #1;
    vectors++; if (ovalid !== 1'b1) begin errors++; $display("FAIL allneg_ovalid got %b want 1", ovalid); end
    vectors++; if (odata !== e) begin errors++; $display("FAIL allneg_data got %h want %h", odata, e); end
    drain();
  endtask

  task automatic test_narrow();
    logic [N*OWN-1:0] e;
    logic [N-1:0]     es;
    logic             s;
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) a[r][c] = (p == 0) ? 255 : (p == 1) ? -256 : int'($urandom_range(15)) - 8;
        b[r] = (p == 2) ? int'($urandom_range(15)) - 8 : 255;
      end
      load_beat();
      for (int r = 0; r < N; r++) begin
        e[r*OWN +: OWN] = narrow(row_val(r), s);
        es[r] = s;
      end
      ivalid = 1'b1; iready = 1'b1;
      @(posedge iclk); #1;
      ivalid = 1'b0;
      @(posedge iclk); #1;
      vectors++; if (ovalid_n !== 1'b1) begin errors++; $display("FAIL narrow%0d_ovalid got %b want 1", p, ovalid_n); end
      vectors++; if (odata_n !== e) begin errors++; $display("FAIL narrow%0d_data got %h want %h", p, odata_n, e); end
      vectors++; if (osat_n !== es) begin errors++; $display("FAIL narrow%0d_osat got %b want %b", p, osat_n, es); end
      vectors++; if (odata !== exp_wide()) begin errors++; $display("FAIL narrow%0d_wide got %h want %h", p, odata, exp_wide()); end
    end
    drain();
  endtask

  task automatic test_stream();
    logic [N*OW-1:0] q[$];
    logic [N*OW-1:0] held;
    logic [N*OW-1:0] front;
    bit held_v = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    while ((sent < 8 || got < 8) && cyc < 200) begin
      iready = (cyc % 2 == 0);
      if (sent < 8 && $urandom_range(3) != 0) begin
        rand_beat(-256, 255);
        ivalid = 1'b1;
      end else begin
        ivalid = 1'b0;
      end
      #1;
      vectors++;
      if (oready !== (iready | ~ovalid)) begin errors++; $display("FAIL stream_oready cyc %0d got %b want %b", cyc, oready, iready | ~ovalid); end
      if (held_v) begin
        vectors++;
        if (ovalid !== 1'b1 || odata !== held) begin errors++; $display("FAIL stream_hold cyc %0d got %b/%h want 1/%h", cyc, ovalid, odata, held); end
      end
      held_v = ovalid && !iready;
      held   = odata;
      if (ovalid && iready) begin
        vectors++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra cyc %0d got %h want none", cyc, odata);
        end else begin
          front = q.pop_front();
          if (odata !== front) begin errors++; $display("FAIL stream_data beat %0d got %h want %h", got, odata, front); end
        end
        got++;
      end
      if (ivalid && oready) begin
        q.push_back(exp_wide());
        sent++;
      end
      @(posedge iclk); #1;
      cyc++;
    end
    vectors++;
    if (cyc >= 200) begin errors++; $display("FAIL stream_timeout got %0d beats want 8", got); end
    drain();
  endtask

  task automatic test_reset_midstall();
    logic [N*OW-1:0] e;
    iready = 1'b0;
    rand_beat(-256, 255); ivalid = 1'b1;
    @(posedge iclk); #1;
    rand_beat(-256, 255);
    @(posedge iclk); #1;
    ivalid = 1'b0;
    @(posedge iclk); #1;
    vectors++; if (ovalid !== 1'b1 || oready !== 1'b0) begin errors++; $display("FAIL stall_state got %b/%b want 1/0", ovalid, oready); end
    #1 irst_n = 1'b0;
    #1;
    vectors++; if (ovalid !== 1'b0 || odata !== '0) begin errors++; $display("FAIL rst_async got %b/%h want 0/0", ovalid, odata); end
    vectors++; if (oready !== 1'b1) begin errors++; $display("FAIL rst_oready got %b want 1", oready); end
    #1 irst_n = 1'b1;
    rand_beat(-256, 255);
    e = exp_wide();
    ivalid = 1'b1; iready = 1'b1;
    @(posedge iclk); #1;
    ivalid = 1'b0;
    vectors++; if (ovalid !== 1'b0) begin errors++; $display("FAIL rst_flush ovalid got %b want 0", ovalid); end
    @(posedge iclk); #1;
    vectors++; if (ovalid !== 1'b1 || odata !== e) begin errors++; $display("FAIL rst_next got %b/%h want 1/%h", ovalid, odata, e); end
    drain();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_neg();
    test_narrow();
    test_stream();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
